// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter for the async FIFO, burst-locked grants with a beat limit.
// Optional statistics counters are enabled by defining FIFO_ARB_STATS_EN.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          W_CLK,
    input  logic                          W_RST,
    input  logic [NUM_REQ-1:0]            REQ_VALID,
    input  logic [NUM_REQ-1:0]            REQ_LAST,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
    output logic [NUM_REQ-1:0]            REQ_READY,
    output logic [NUM_REQ-1:0]            GNT,
    input  logic                          W_FULL,
    output logic                          W_INC,
    output logic [DATA_WIDTH-1:0]         W_DATA,
    output logic                          BURST_ABORT
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [NUM_REQ*CNT_WIDTH-1:0]  STAT_BEATS,
    output logic [CNT_WIDTH-1:0]          STAT_ABORTS
`endif
);

    localparam int IW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BW  = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
    localparam int LIM = (MAX_BURST > 0) ? MAX_BURST - 1 : 0;

    if (NUM_REQ < 2 || NUM_REQ > 8 || CNT_WIDTH < 1) begin : g_bad_param
        $error("fifo_wr_arbiter: unsupported parameter value");
    end

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t        state;
    logic [IW-1:0] last_grant;
    logic [IW-1:0] gnt_idx;
    logic [IW-1:0] next_idx;
    logic [BW-1:0] beat_cnt;
    logic          found;
    logic          gnt_last;
    logic          limit_hit;
    logic          abort_now;
    int            cand;

    assign REQ_READY = GNT & {NUM_REQ{~W_FULL}};
    assign W_INC     = (|(GNT & REQ_VALID)) & ~W_FULL;
    assign gnt_last  = |(GNT & REQ_LAST);
    assign limit_hit = (MAX_BURST != 0) && (beat_cnt == BW'(LIM));
    assign abort_now = (state == BURST) && W_INC && !gnt_last && limit_hit;

    always_comb begin
        gnt_idx = '0;
        W_DATA  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (GNT[i]) gnt_idx = IW'(i);
            W_DATA = W_DATA
                   | ({DATA_WIDTH{GNT[i]}} & REQ_DATA[i*DATA_WIDTH +: DATA_WIDTH]);
        end
    end

    // Scan starts just past the previous winner and wraps around.
    always_comb begin
        next_idx = '0;
        found    = 1'b0;
        cand     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(last_grant) + k) % NUM_REQ;
            if (!found && REQ_VALID[IW'(cand)]) begin
                found    = 1'b1;
                next_idx = IW'(cand);
            end
        end
    end

    always_ff @(posedge W_CLK or negedge W_RST) begin
        if (!W_RST) begin
            state       <= IDLE;
            GNT         <= '0;
            last_grant  <= IW'(NUM_REQ - 1);
            beat_cnt    <= '0;
            BURST_ABORT <= 1'b0;
        end else begin
            BURST_ABORT <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        GNT      <= NUM_REQ'(1) << next_idx;
                        beat_cnt <= '0;
                        state    <= BURST;
                    end
                end
                BURST: begin
                    if (W_INC) begin
                        if (gnt_last) begin
                            GNT        <= '0;
                            last_grant <= gnt_idx;
                            beat_cnt   <= '0;
                            state      <= IDLE;
                        end else if (limit_hit) begin
                            GNT         <= '0;
                            last_grant  <= gnt_idx;
                            beat_cnt    <= '0;
                            BURST_ABORT <= 1'b1;
                            state       <= IDLE;
                        end else if (!(&beat_cnt)) begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    GNT   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef FIFO_ARB_STATS_EN
    always_ff @(posedge W_CLK or negedge W_RST) begin
        if (!W_RST) begin
            STAT_BEATS  <= '0;
            STAT_ABORTS <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (W_INC && GNT[i]
                    && !(&STAT_BEATS[i*CNT_WIDTH +: CNT_WIDTH])) begin
                    STAT_BEATS[i*CNT_WIDTH +: CNT_WIDTH] <=
                        STAT_BEATS[i*CNT_WIDTH +: CNT_WIDTH] + 1'b1;
                end
            end
            if (abort_now && !(&STAT_ABORTS)) begin
                STAT_ABORTS <= STAT_ABORTS + 1'b1;
            end
        end
    end
`endif

endmodule
